// File: rtl/id_ex_stage_reg_pkg.sv
// Shared core definitions: ALU op classes, control bundle, default widths.
// The bubble constant is the all-zero control word.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       alusrc;
    logic [1:0] aluop;
    logic [2:0] func3;
    logic       func7bit;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    branch:   1'b0,
    alusrc:   1'b0,
    aluop:    ALUOP_ADD,
    func3:    3'b000,
    func7bit: 1'b0
  };

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID -> EX bundle: decoded fields in, registered fields out,
// plus the load-use stall request back towards PC and IF/ID.
interface id_ex_stage_reg_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);

  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [XLEN-1:0] id_rs1_data_i;
  logic [XLEN-1:0] id_rs2_data_i;
  logic [XLEN-1:0] id_imm_i;
  logic [RA_W-1:0] id_rs1_i;
  logic [RA_W-1:0] id_rs2_i;
  logic [RA_W-1:0] id_rd_i;
  logic            id_regwrite_i;
  logic            id_memread_i;
  logic            id_memwrite_i;
  logic            id_memtoreg_i;
  logic            id_branch_i;
  logic            id_alusrc_i;
  logic [1:0]      id_aluop_i;
  logic [2:0]      id_func3_i;
  logic            id_func7bit_i;

  logic            ex_valid_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] ex_rs1_data_o;
  logic [XLEN-1:0] ex_rs2_data_o;
  logic [XLEN-1:0] ex_imm_o;
  logic [RA_W-1:0] ex_rs1_o;
  logic [RA_W-1:0] ex_rs2_o;
  logic [RA_W-1:0] ex_rd_o;
  logic            ex_regwrite_o;
  logic            ex_memread_o;
  logic            ex_memwrite_o;
  logic            ex_memtoreg_o;
  logic            ex_branch_o;
  logic            ex_alusrc_o;
  logic [1:0]      ex_aluop_o;
  logic [2:0]      ex_func3_o;
  logic            ex_func7bit_o;

  logic            load_use_stall_o;

  modport master (
    output id_valid_i, id_pc_i,
    output id_rs1_data_i, id_rs2_data_i,
    output id_imm_i,
    output id_rs1_i, id_rs2_i, id_rd_i,
    output id_regwrite_i, id_memread_i,
    output id_memwrite_i, id_memtoreg_i,
    output id_branch_i, id_alusrc_i,
    output id_aluop_i, id_func3_i,
    output id_func7bit_i,
    input  ex_valid_o, ex_pc_o,
    input  ex_rs1_data_o, ex_rs2_data_o,
    input  ex_imm_o,
    input  ex_rs1_o, ex_rs2_o, ex_rd_o,
    input  ex_regwrite_o, ex_memread_o,
    input  ex_memwrite_o, ex_memtoreg_o,
    input  ex_branch_o, ex_alusrc_o,
    input  ex_aluop_o, ex_func3_o,
    input  ex_func7bit_o,
    input  load_use_stall_o
  );

  modport slave (
    input  id_valid_i, id_pc_i,
    input  id_rs1_data_i, id_rs2_data_i,
    input  id_imm_i,
    input  id_rs1_i, id_rs2_i, id_rd_i,
    input  id_regwrite_i, id_memread_i,
    input  id_memwrite_i, id_memtoreg_i,
    input  id_branch_i, id_alusrc_i,
    input  id_aluop_i, id_func3_i,
    input  id_func7bit_i,
    output ex_valid_o, ex_pc_o,
    output ex_rs1_data_o, ex_rs2_data_o,
    output ex_imm_o,
    output ex_rs1_o, ex_rs2_o, ex_rd_o,
    output ex_regwrite_o, ex_memread_o,
    output ex_memwrite_o, ex_memtoreg_o,
    output ex_branch_o, ex_alusrc_o,
    output ex_aluop_o, ex_func3_o,
    output ex_func7bit_o,
    output load_use_stall_o
  );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard: a valid load in EX whose rd feeds either
// source of the instruction in ID. x0 never hazards.
module load_use_detect #(
  parameter int RA_W = 5
) (
  input  logic            ex_valid_i,
  input  logic            ex_memread_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            id_valid_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  output logic            hazard_o
);

  logic rd_nz;
  logic rs_hit;

  assign rd_nz  = (ex_rd_i != '0);
  assign rs_hit = (ex_rd_i == id_rs1_i)
                | (ex_rd_i == id_rs2_i);

  assign hazard_o = ex_valid_i & ex_memread_i
                  & rd_nz & id_valid_i & rs_hit;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble injection on flush,
// hold on external stall, and load-use stall generation.
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               stall_i,
  id_ex_stage_reg_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } data_t;

  logic  valid_d, valid_q;
  ctrl_t ctrl_d, ctrl_q, id_ctrl;
  data_t data_d, data_q, id_data;
  logic  hazard;

  assign id_ctrl = {
    bus.id_regwrite_i, bus.id_memread_i,
    bus.id_memwrite_i, bus.id_memtoreg_i,
    bus.id_branch_i,   bus.id_alusrc_i,
    bus.id_aluop_i,    bus.id_func3_i,
    bus.id_func7bit_i
  };

  assign id_data = {
    bus.id_pc_i,
    bus.id_rs1_data_i, bus.id_rs2_data_i,
    bus.id_imm_i,
    bus.id_rs1_i, bus.id_rs2_i, bus.id_rd_i
  };

  load_use_detect #(.RA_W(RA_W)) u_lud (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q.memread),
    .ex_rd_i      (data_q.rd),
    .id_valid_i   (bus.id_valid_i),
    .id_rs1_i     (bus.id_rs1_i),
    .id_rs2_i     (bus.id_rs2_i),
    .hazard_o     (hazard)
  );

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    priority case (1'b1)
      flush_i: begin
        valid_d = 1'b0;
        ctrl_d  = BUBBLE;
        data_d  = '0;
      end
      stall_i: begin
      end
      hazard: begin
        valid_d = 1'b0;
        ctrl_d  = BUBBLE;
        data_d  = '0;
      end
      default: begin
        valid_d = bus.id_valid_i;
        ctrl_d  = bus.id_valid_i ? id_ctrl
                                 : BUBBLE;
        data_d  = id_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= BUBBLE;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  // A flushed ID instruction is squashed upstream, so no stall.
  assign bus.load_use_stall_o = hazard & ~flush_i;

  assign bus.ex_valid_o = valid_q;
  assign {
    bus.ex_regwrite_o, bus.ex_memread_o,
    bus.ex_memwrite_o, bus.ex_memtoreg_o,
    bus.ex_branch_o,   bus.ex_alusrc_o,
    bus.ex_aluop_o,    bus.ex_func3_o,
    bus.ex_func7bit_o
  } = ctrl_q;
  assign {
    bus.ex_pc_o,
    bus.ex_rs1_data_o, bus.ex_rs2_data_o,
    bus.ex_imm_o,
    bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o
  } = data_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomised and directed bench for id_ex_stage_reg against a
// field-level reference model of the ID/EX stage rules.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, mtr, br, as;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } st_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic stall;

  int npass = 0;
  int ntotal = 0;

  st_t m;
  st_t cin;
  logic cfl, csl;

  id_ex_stage_reg_if #(.XLEN(32), .RA_W(5)) bus ();

  id_ex_stage_reg #(.XLEN(32), .RA_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .stall_i (stall),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic st_t dut_st();
    st_t s;
    s.v   = bus.ex_valid_o;
    s.pc  = bus.ex_pc_o;
    s.a   = bus.ex_rs1_data_o;
    s.b   = bus.ex_rs2_data_o;
    s.imm = bus.ex_imm_o;
    s.rs1 = bus.ex_rs1_o;
    s.rs2 = bus.ex_rs2_o;
    s.rd  = bus.ex_rd_o;
    s.rw  = bus.ex_regwrite_o;
    s.mr  = bus.ex_memread_o;
    s.mw  = bus.ex_memwrite_o;
    s.mtr = bus.ex_memtoreg_o;
    s.br  = bus.ex_branch_o;
    s.as  = bus.ex_alusrc_o;
    s.op  = bus.ex_aluop_o;
    s.f3  = bus.ex_func3_o;
    s.f7  = bus.ex_func7bit_o;
    return s;
  endfunction

  function automatic st_t rand_in();
    logic [159:0] r;
    st_t s;
    r = {$urandom, $urandom, $urandom,
         $urandom, $urandom};
    s = r[$bits(st_t)-1:0];
    s.rd  = 5'($urandom_range(0, 3));
    s.rs1 = 5'($urandom_range(0, 3));
    s.rs2 = 5'($urandom_range(0, 3));
    s.mr  = ($urandom_range(0, 9) < 4);
    s.v   = ($urandom_range(0, 7) != 0);
    return s;
  endfunction

  // Load in EX whose destination is read by the ID instruction.
  function automatic logic model_hazard();
    if (!(m.v && m.mr && cin.v)) return 1'b0;
    if (m.rd == 5'd0) return 1'b0;
    return (m.rd == cin.rs1) || (m.rd == cin.rs2);
  endfunction

  function automatic st_t model_next();
    st_t n;
    if (cfl) return '0;
    if (csl) return m;
    if (model_hazard()) return '0;
    n = cin;
    if (!cin.v) begin
      n.rw = 0; n.mr = 0; n.mw = 0;
      n.mtr = 0; n.br = 0; n.as = 0;
      n.op = 0; n.f3 = 0; n.f7 = 0;
    end
    return n;
  endfunction

  task automatic put(st_t s, logic fl, logic sl);
    bus.id_valid_i    = s.v;
    bus.id_pc_i       = s.pc;
    bus.id_rs1_data_i = s.a;
    bus.id_rs2_data_i = s.b;
    bus.id_imm_i      = s.imm;
    bus.id_rs1_i      = s.rs1;
    bus.id_rs2_i      = s.rs2;
    bus.id_rd_i       = s.rd;
    bus.id_regwrite_i = s.rw;
    bus.id_memread_i  = s.mr;
    bus.id_memwrite_i = s.mw;
    bus.id_memtoreg_i = s.mtr;
    bus.id_branch_i   = s.br;
    bus.id_alusrc_i   = s.as;
    bus.id_aluop_i    = s.op;
    bus.id_func3_i    = s.f3;
    bus.id_func7bit_i = s.f7;
    flush = fl;
    stall = sl;
    cin = s; cfl = fl; csl = sl;
    #1;
  endtask

  task automatic tick();
    st_t n;
    n = model_next();
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic test_reset();
    st_t s;
    rst_n = 1'b0;
    put('0, 1'b0, 1'b0);
    m = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    s = '1;
    s.pc = 32'h1234_5678; s.a = 32'hDEAD_BEEF;
    s.b = 32'h0BAD_F00D; s.imm = 32'hFFFF_F800;
    s.rs1 = 5'd3; s.rs2 = 5'd4; s.rd = 5'd9;
    put(s, 1'b0, 1'b0);
    tick();
    ntotal++;
    if (dut_st() !== s) $display("FAIL reset_preload got %h exp %h", dut_st(), s);
    else npass++;
    #2 rst_n = 1'b0;
    #1;
    ntotal++;
    if (dut_st() !== st_t'('0)) $display("FAIL reset_async got %h exp 0", dut_st());
    else npass++;
    ntotal++;
    if (bus.load_use_stall_o !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.load_use_stall_o);
    else npass++;
    m = '0;
    @(posedge clk);
    #1;
    ntotal++;
    if (dut_st() !== st_t'('0)) $display("FAIL reset_hold got %h exp 0", dut_st());
    else npass++;
    #2 rst_n = 1'b1;
    put(s, 1'b0, 1'b0);
    tick();
    ntotal++;
    if (dut_st() !== s) $display("FAIL reset_release got %h exp %h", dut_st(), s);
    else npass++;
  endtask

  task automatic test_normal();
    st_t s;
    s = '0;
    s.v = 1; s.op = 2'b10; s.f3 = 3'b111;
    s.f7 = 0; s.a = 32'h0000_00F0; s.rw = 1;
    s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3;
    put(s, 1'b0, 1'b0);
    tick();
    ntotal++;
    if (bus.ex_aluop_o !== 2'b10 || bus.ex_func3_o !== 3'b111
        || bus.ex_rs1_data_o !== 32'hF0 || bus.ex_regwrite_o !== 1'b1)
      $display("FAIL normal_fields got op=%b f3=%b a=%h rw=%b exp 10 111 f0 1",
               bus.ex_aluop_o, bus.ex_func3_o, bus.ex_rs1_data_o, bus.ex_regwrite_o);
    else npass++;
    ntotal++;
    if (dut_st() !== m) $display("FAIL normal_all got %h exp %h", dut_st(), m);
    else npass++;
  endtask

  task automatic test_load_use(input logic [4:0] rd);
    st_t lw, add;
    logic exp_stall;
    lw = rand_in(); lw.v = 1; lw.mr = 1; lw.rd = rd;
    lw.rs1 = 5'd0; lw.rs2 = 5'd0;
    add = rand_in(); add.v = 1; add.mr = 0; add.rw = 1;
    add.rs1 = rd; add.rs2 = 5'd7; add.rd = 5'd6;
    exp_stall = (rd != 5'd0);
    put(lw, 1'b0, 1'b0);
    tick();
    put(add, 1'b0, 1'b0);
    ntotal++;
    if (bus.load_use_stall_o !== exp_stall)
      $display("FAIL lu_stall rd=%0d got %b exp %b", rd, bus.load_use_stall_o, exp_stall);
    else npass++;
    tick();
    if (exp_stall) begin
      ntotal++;
      if (bus.ex_valid_o !== 0 || bus.ex_regwrite_o !== 0 || bus.ex_aluop_o !== 2'b00)
        $display("FAIL lu_bubble got v=%b rw=%b op=%b exp 0 0 00",
                 bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_aluop_o);
      else npass++;
      ntotal++;
      if (bus.load_use_stall_o !== 1'b0)
        $display("FAIL lu_one_cycle got %b exp 0", bus.load_use_stall_o);
      else npass++;
      tick();
    end
    ntotal++;
    if (bus.ex_valid_o !== 1 || bus.ex_rs1_o !== rd || bus.ex_rs2_o !== 5'd7)
      $display("FAIL lu_capture rd=%0d got v=%b rs1=%0d rs2=%0d exp 1 %0d 7",
               rd, bus.ex_valid_o, bus.ex_rs1_o, bus.ex_rs2_o, rd);
    else npass++;
  endtask

  task automatic test_flush_priority();
    st_t lw, add;
    lw = rand_in(); lw.v = 1; lw.mr = 1; lw.rd = 5'd5;
    add = rand_in(); add.v = 1; add.rs1 = 5'd5; add.rs2 = 5'd7;
    put(lw, 1'b0, 1'b0);
    tick();
    put(add, 1'b1, 1'b0);
    ntotal++;
    if (bus.load_use_stall_o !== 1'b0)
      $display("FAIL flush_stall got %b exp 0", bus.load_use_stall_o);
    else npass++;
    tick();
    ntotal++;
    if (dut_st() !== st_t'('0)) $display("FAIL flush_bubble got %h exp 0", dut_st());
    else npass++;
  endtask

  task automatic test_stall_hold();
    st_t s, saved;
    s = rand_in(); s.v = 1; s.mr = 0;
    put(s, 1'b0, 1'b0);
    tick();
    saved = s;
    for (int i = 0; i < 3; i++) begin
      put(rand_in(), 1'b0, 1'b1);
      tick();
      ntotal++;
      if (dut_st() !== saved) $display("FAIL stall_hold%0d got %h exp %h", i, dut_st(), saved);
      else npass++;
    end
    s = rand_in(); s.v = 1;
    put(s, 1'b0, 1'b0);
    tick();
    ntotal++;
    if (dut_st() !== s) $display("FAIL stall_release got %h exp %h", dut_st(), s);
    else npass++;
  endtask

  task automatic test_stall_hazard();
    st_t lw, add;
    lw = rand_in(); lw.v = 1; lw.mr = 1; lw.rd = 5'd2;
    add = rand_in(); add.v = 1; add.rs1 = 5'd1; add.rs2 = 5'd2;
    put(lw, 1'b0, 1'b0);
    tick();
    put(add, 1'b0, 1'b1);
    ntotal++;
    if (bus.load_use_stall_o !== 1'b1) $display("FAIL sh_stall got %b exp 1", bus.load_use_stall_o);
    else npass++;
    tick();
    ntotal++;
    if (dut_st() !== lw) $display("FAIL sh_hold got %h exp %h", dut_st(), lw);
    else npass++;
    put(add, 1'b0, 1'b0);
    ntotal++;
    if (bus.load_use_stall_o !== 1'b1) $display("FAIL sh_reeval got %b exp 1", bus.load_use_stall_o);
    else npass++;
    tick();
    ntotal++;
    if (dut_st() !== st_t'('0)) $display("FAIL sh_bubble got %h exp 0", dut_st());
    else npass++;
  endtask

  task automatic test_invalid_id();
    st_t s;
    s = rand_in(); s.v = 0; s.rw = 1; s.mw = 1;
    put(s, 1'b0, 1'b0);
    tick();
    ntotal++;
    if (bus.ex_regwrite_o !== 0 || bus.ex_memwrite_o !== 0 || bus.ex_valid_o !== 0)
      $display("FAIL invalid_ctrl got rw=%b mw=%b v=%b exp 0 0 0",
               bus.ex_regwrite_o, bus.ex_memwrite_o, bus.ex_valid_o);
    else npass++;
    ntotal++;
    if (bus.ex_pc_o !== s.pc) $display("FAIL invalid_pc got %h exp %h", bus.ex_pc_o, s.pc);
    else npass++;
  endtask

  task automatic test_random();
    logic es;
    for (int i = 0; i < 300; i++) begin
      put(rand_in(), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 6) == 0));
      es = model_hazard() && !cfl;
      ntotal++;
      if (bus.load_use_stall_o !== es)
        $display("FAIL rand_stall%0d got %b exp %b", i, bus.load_use_stall_o, es);
      else npass++;
      tick();
      ntotal++;
      if (dut_st() !== m) $display("FAIL rand_state%0d got %h exp %h", i, dut_st(), m);
      else npass++;
    end
  endtask

  initial begin
    flush = 0;
    stall = 0;
    rst_n = 0;
    test_reset();
    test_normal();
    test_load_use(5'd5);
    test_load_use(5'd0);
    test_flush_priority();
    test_stall_hold();
    test_stall_hazard();
    test_invalid_id();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, directly upstream of the ALU control unit and ALU.
- Captures decoded control bits (including aluop/func3/func7bit), operands, immediate and register indices from ID.
- Presents them registered to EX.
- Contains load-use hazard detection: injects a bubble and drives a stall request to PC and IF/ID.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate
- RA_W, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  squash ID/EX contents (branch taken / jump resolved in EX/MEM)
- stall_i  in  1  external hold (memory wait); freezes register
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  RA_W  register indices
- id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i, id_branch_i, id_alusrc_i  in  1 each  main-decoder control
- id_aluop_i  in  2  ALU op class
- id_func3_i  in  3  instr[14:12]
- id_func7bit_i  in  1  instr[30]
- ex_* outputs  out  same widths  registered copies of every id_* input above, including ex_valid_o
- load_use_stall_o  out  1  request to hold PC and IF/ID this cycle

Behaviour:
- Reset: async on rst_n low. Every ex_* output clears to 0, including ex_valid_o, all control bits, aluop=2'b00, data and indices. load_use_stall_o=0 while in reset.
- Hazard (combinational from current registered state):
  - hazard = ex_valid_o & ex_memread_o & (ex_rd_o != 0) & id_valid_i & ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)).
  - load_use_stall_o = hazard & ~flush_i.
  - No rs-usage qualification: false stalls on unused rs2 are accepted.
- Per rising edge, first matching rule in priority order:
  1. flush_i=1: load bubble. ex_valid_o=0, regwrite/memread/memwrite/memtoreg/branch/alusrc=0, aluop=00, func3=000, func7bit=0. Data and index fields are don't-care but cleared to 0 (deterministic for verification).
  2. stall_i=1: hold all fields unchanged, including an existing bubble.
  3. hazard=1: load bubble; the ID instruction is retained upstream by load_use_stall_o.
  4. else: capture all id_* inputs. If id_valid_i=0, control bits are forced to bubble values regardless of inputs.
- Latency: 1 cycle ID→EX. Load-use costs exactly 1 bubble: the next cycle ex_memread_o=0, so the hazard clears.
- Bubble has aluop=00, so the ALU control selects ADD. This is harmless because regwrite=memwrite=memread=0.
- flush and hazard together: flush wins and the stall request is suppressed, because the ID instruction is also squashed upstream.
- stall_i and hazard together: hold, with load_use_stall_o still asserted. The hazard re-evaluates after stall_i drops.
- rd=x0 never raises hazard.
- Reset deasserting mid-stream: the first edge after release loads normally.

Decomposition:
- Shared package core_pkg:
  - ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10
  - BUBBLE control constant (all zeros)
  - XLEN/RA_W defaults
- Sub-module load_use_detect: pure combinational hazard equation. The register itself stays in id_ex_stage_reg.

Test Plan:
- Reset: drive all id_* inputs nonzero, pulse rst_n low mid-cycle → all ex_* outputs read 0 immediately (async), load_use_stall_o=0.
- Normal flow: id_aluop=10, func3=111, func7bit=0, rs1_data=0x0000_00F0, regwrite=1, valid=1 → the next edge gives ex_aluop=10, ex_func3=111, ex_rs1_data=0x0000_00F0, ex_regwrite=1.
- Load-use:
  - Stimulus: lw x5 in EX (memread=1, rd=5), then add x6,x5,x7 in ID.
  - Response: load_use_stall_o=1 for exactly one cycle; the next edge loads a bubble (ex_valid=0, regwrite=0, aluop=00); the following edge captures the add (rs1=5, rs2=7).
  - Repeat with rd=0 → no stall.
- Flush priority: hazard condition present and flush_i=1 → load_use_stall_o=0; the next edge gives a bubble and ex_memread=0.
- Stall hold: stall_i=1 for 3 cycles while id_* inputs change every cycle → ex_* outputs stay constant. On release, the current id_* inputs are captured on the next edge.
- Invalid ID: id_valid=0 with id_regwrite=1, id_memwrite=1 → ex_regwrite=0, ex_memwrite=0, ex_valid=0.
